// File: rtl/cmp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmp_pkg : op codes and width-generic compare evaluation for compare_unit_pipe
// Revision: 1.0
// ---------------------------------------------------------------------------
package cmp_pkg;

    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_NE   = 4'b1011;
    localparam logic [3:0] OP_GE   = 4'b1100;
    localparam logic [3:0] OP_GEU  = 4'b1101;
    localparam logic [3:0] OP_MIN  = 4'b1110;
    localparam logic [3:0] OP_MAX  = 4'b1111;

    // Widest operand the evaluator handles; narrower callers zero-extend.
    localparam int CMP_MAXW = 64;

    typedef struct packed {
        logic                illegal;
        logic                cond;
        logic [CMP_MAXW-1:0] result;
    } cmp_res_t;

    // Operands arrive zero-extended, so the unsigned compare is exact at any
    // width; the signed view only needs the sign bit at position xlen-1.
    function automatic cmp_res_t cmp_eval(
        input logic [CMP_MAXW-1:0] a,
        input logic [CMP_MAXW-1:0] b,
        input logic [3:0]          op,
        input logic [6:0]          xlen
    );
        cmp_res_t   res;
        logic [5:0] msb;
        logic       a_neg;
        logic       b_neg;
        logic       a_ltu;
        logic       b_ltu;
        logic       a_lt;
        logic       b_lt;
        logic       eq;

        res   = '0;
        msb   = 6'(xlen - 7'd1);
        a_neg = a[msb];
        b_neg = b[msb];
        a_ltu = (a < b);
        b_ltu = (b < a);
        eq    = (a == b);
        a_lt  = (a_neg != b_neg) ? a_neg : a_ltu;
        b_lt  = (a_neg != b_neg) ? b_neg : b_ltu;

        case (op)
            OP_SLT:  res.cond = a_lt;
            OP_SLTU: res.cond = a_ltu;
            OP_EQ:   res.cond = eq;
            OP_NE:   res.cond = !eq;
            OP_GE:   res.cond = !a_lt;
            OP_GEU:  res.cond = !a_ltu;
            OP_MIN:  res.cond = !b_lt;
            OP_MAX:  res.cond = !a_lt;
            default: res.illegal = 1'b1;
        endcase

        if (op == OP_MIN || op == OP_MAX) begin
            res.result = res.cond ? a : b;
        end else if (!res.illegal) begin
            res.result = {{(CMP_MAXW-1){1'b0}}, res.cond};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmp_core : combinational XLEN-wide compare / min / max evaluation
// Revision: 1.0
// ---------------------------------------------------------------------------
module cmp_core
    import cmp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rs_1,
    input  logic [XLEN-1:0] i_rs_2,
    input  logic [3:0]      i_op,
    output logic [XLEN-1:0] o_result,
    output logic            o_cond,
    output logic            o_illegal
);

    cmp_res_t w_res;
    logic     w_unused;

    assign w_res     = cmp_eval(CMP_MAXW'(i_rs_1), CMP_MAXW'(i_rs_2), i_op, 7'(XLEN));
    assign o_result  = w_res.result[XLEN-1:0];
    assign o_cond    = w_res.cond;
    assign o_illegal = w_res.illegal;

    // Upper evaluator bits are always zero for narrow instances.
    assign w_unused  = &{1'b0, w_res.result};

endmodule
`default_nettype wire

// File: rtl/compare_unit_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// compare_unit_pipe : 1- or 2-stage valid/ready compare unit with tag passthrough
// Revision: 1.0
// ---------------------------------------------------------------------------
module compare_unit_pipe
    import cmp_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  rs_1,
    input  logic [XLEN-1:0]  rs_2,
    input  logic [3:0]       alu_ctrl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result_cmp,
    output logic             cond_true,
    output logic             illegal_op,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  w_core_a;
    logic [XLEN-1:0]  w_core_b;
    logic [3:0]       w_core_op;
    logic [TAG_W-1:0] w_core_tag;
    logic             w_core_valid;
    logic [XLEN-1:0]  w_core_result;
    logic             w_core_cond;
    logic             w_core_illegal;
    logic             w_s2_ready;

    logic             r_s2_valid;
    logic [XLEN-1:0]  r_result;
    logic             r_cond;
    logic             r_illegal;
    logic [TAG_W-1:0] r_tag;

    assign w_s2_ready = !r_s2_valid || out_ready;

    generate
        if (XLEN < 2 || XLEN > CMP_MAXW) begin : g_bad_xlen
            $error("compare_unit_pipe: XLEN out of supported range");
        end

        if (STAGES == 2) begin : g_two_stage
            logic             r_s1_valid;
            logic [XLEN-1:0]  r_s1_a;
            logic [XLEN-1:0]  r_s1_b;
            logic [3:0]       r_s1_op;
            logic [TAG_W-1:0] r_s1_tag;

            assign in_ready = !r_s1_valid || w_s2_ready;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_s1_valid <= 1'b0;
                    r_s1_a     <= '0;
                    r_s1_b     <= '0;
                    r_s1_op    <= '0;
                    r_s1_tag   <= '0;
                end else if (in_ready) begin
                    r_s1_valid <= in_valid;
                    if (in_valid) begin
                        r_s1_a   <= rs_1;
                        r_s1_b   <= rs_2;
                        r_s1_op  <= alu_ctrl;
                        r_s1_tag <= in_tag;
                    end
                end
            end

            assign w_core_valid = r_s1_valid;
            assign w_core_a     = r_s1_a;
            assign w_core_b     = r_s1_b;
            assign w_core_op    = r_s1_op;
            assign w_core_tag   = r_s1_tag;
        end else if (STAGES == 1) begin : g_one_stage
            assign in_ready     = w_s2_ready;
            assign w_core_valid = in_valid;
            assign w_core_a     = rs_1;
            assign w_core_b     = rs_2;
            assign w_core_op    = alu_ctrl;
            assign w_core_tag   = in_tag;
        end else begin : g_bad_stages
            $error("compare_unit_pipe: STAGES must be 1 or 2");
        end
    endgenerate

    cmp_core #(
        .XLEN (XLEN)
    ) u_core (
        .i_rs_1    (w_core_a),
        .i_rs_2    (w_core_b),
        .i_op      (w_core_op),
        .o_result  (w_core_result),
        .o_cond    (w_core_cond),
        .o_illegal (w_core_illegal)
    );

    // Result register only reloads on a real beat so a drained output keeps its data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_cond     <= 1'b0;
            r_illegal  <= 1'b0;
            r_tag      <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= w_core_valid;
            if (w_core_valid) begin
                r_result  <= w_core_result;
                r_cond    <= w_core_cond;
                r_illegal <= w_core_illegal;
                r_tag     <= w_core_tag;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign result_cmp = r_result;
    assign cond_true  = r_cond;
    assign illegal_op = r_illegal;
    assign out_tag    = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_compare_unit_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_compare_unit_pipe : scoreboard bench for compare_unit_pipe (2-stage/32b and 1-stage/8b)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_compare_unit_pipe;

    localparam int STAGES = 2;

    typedef struct {
        logic [31:0] result;
        logic        cond;
        logic        illegal;
        logic [3:0]  tag;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs_1;
    logic [31:0] rs_2;
    logic [3:0]  alu_ctrl;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_cmp;
    logic        cond_true;
    logic        illegal_op;
    logic [3:0]  out_tag;

    logic        d1_in_valid;
    logic        d1_in_ready;
    logic [7:0]  d1_rs_1;
    logic [7:0]  d1_rs_2;
    logic [3:0]  d1_alu_ctrl;
    logic [3:0]  d1_in_tag;
    logic        d1_out_valid;
    logic        d1_out_ready;
    logic [7:0]  d1_result_cmp;
    logic        d1_cond_true;
    logic        d1_illegal_op;
    logic [3:0]  d1_out_tag;

    int          n_checks;
    int          n_errors;
    int          cyc;
    bit          strict_lat;
    bit          head_seen;
    bit          track_bubbles;
    int          last_out;
    bit          hold_prev;
    logic [31:0] prev_result;
    logic        prev_cond;
    logic        prev_illegal;
    logic [3:0]  prev_tag;
    exp_t        q[$];

    compare_unit_pipe #(.XLEN(32), .TAG_W(4), .STAGES(2)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs_1       (rs_1),
        .rs_2       (rs_2),
        .alu_ctrl   (alu_ctrl),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_cmp (result_cmp),
        .cond_true  (cond_true),
        .illegal_op (illegal_op),
        .out_tag    (out_tag)
    );

    compare_unit_pipe #(.XLEN(8), .TAG_W(4), .STAGES(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (d1_in_valid),
        .in_ready   (d1_in_ready),
        .rs_1       (d1_rs_1),
        .rs_2       (d1_rs_2),
        .alu_ctrl   (d1_alu_ctrl),
        .in_tag     (d1_in_tag),
        .out_valid  (d1_out_valid),
        .out_ready  (d1_out_ready),
        .result_cmp (d1_result_cmp),
        .cond_true  (d1_cond_true),
        .illegal_op (d1_illegal_op),
        .out_tag    (d1_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference behaviour straight from the op table, using native signed ints.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op, input logic [3:0] tag);
        exp_t m;
        int   sa;
        int   sb;
        sa        = a;
        sb        = b;
        m.result  = '0;
        m.cond    = 1'b0;
        m.illegal = 1'b0;
        m.tag     = tag;
        m.due     = 0;
        case (op)
            4'd8:    m.cond = (sa < sb);
            4'd9:    m.cond = (a < b);
            4'd10:   m.cond = (a == b);
            4'd11:   m.cond = (a != b);
            4'd12:   m.cond = (sa >= sb);
            4'd13:   m.cond = (a >= b);
            4'd14:   m.cond = (sa <= sb);
            4'd15:   m.cond = (sa >= sb);
            default: m.illegal = 1'b1;
        endcase
        if (op == 4'd14 || op == 4'd15) m.result = m.cond ? a : b;
        else if (!m.illegal)            m.result = {31'b0, m.cond};
        return m;
    endfunction

    // One clock: sample at negedge, score transfers, then advance past posedge.
    task automatic tick(output bit took);
        exp_t e;
        @(negedge clk);
        took = 1'b0;
        chk("in_ready", in_ready, (q.size() < STAGES) || out_ready);
        if (hold_prev) begin
            chk("stall_valid",   out_valid,  1'b1);
            chk("stall_result",  result_cmp, prev_result);
            chk("stall_cond",    cond_true,  prev_cond);
            chk("stall_illegal", illegal_op, prev_illegal);
            chk("stall_tag",     out_tag,    prev_tag);
        end
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1'b1, 1'b0);
            end else begin
                if (!head_seen) begin
                    if (strict_lat) chk("latency", cyc, q[0].due);
                    else            chk("latency_min", (cyc >= q[0].due), 1'b1);
                    head_seen = 1'b1;
                end
                if (out_ready) begin
                    e = q.pop_front();
                    head_seen = 1'b0;
                    chk("result",  result_cmp, e.result);
                    chk("cond",    cond_true,  e.cond);
                    chk("illegal", illegal_op, e.illegal);
                    chk("tag",     out_tag,    e.tag);
                    if (track_bubbles) begin
                        if (last_out >= 0) chk("bubble", cyc, last_out + 1);
                        last_out = cyc;
                    end
                end
            end
        end
        hold_prev    = rst_n && out_valid && !out_ready;
        prev_result  = result_cmp;
        prev_cond    = cond_true;
        prev_illegal = illegal_op;
        prev_tag     = out_tag;
        if (rst_n && in_valid && in_ready) begin
            e     = model(rs_1, rs_2, alu_ctrl, in_tag);
            e.due = cyc + STAGES;
            q.push_back(e);
            took  = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            head_seen = 1'b0;
            hold_prev = 1'b0;
        end
        cyc++;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [3:0] tag);
        bit took;
        in_valid = 1'b1;
        rs_1     = a;
        rs_2     = b;
        alu_ctrl = op;
        in_tag   = tag;
        took     = 1'b0;
        for (int i = 0; i < 20 && !took; i++) tick(took);
        if (!took) chk("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit took;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) tick(took);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        bit   took;
        int   sent;
        logic [31:0] ra;
        logic [31:0] rb;

        n_checks = 0;  n_errors = 0;  cyc = 0;
        strict_lat = 1'b1;  head_seen = 1'b0;  track_bubbles = 1'b0;
        last_out = -1;  hold_prev = 1'b0;
        rst_n = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
        rs_1 = '0;  rs_2 = '0;  alu_ctrl = '0;  in_tag = '0;
        d1_in_valid = 1'b0;  d1_out_ready = 1'b1;
        d1_rs_1 = '0;  d1_rs_2 = '0;  d1_alu_ctrl = '0;  d1_in_tag = '0;
        @(posedge clk);
        #1;
        tick(took);
        tick(took);
        chk("rst_out_valid", out_valid,  1'b0);
        chk("rst_result",    result_cmp, 32'd0);
        chk("rst_cond",      cond_true,  1'b0);
        chk("rst_illegal",   illegal_op, 1'b0);
        chk("rst_tag",       out_tag,    4'd0);
        chk("rst_d1_valid",  d1_out_valid, 1'b0);
        rst_n = 1'b1;
        tick(took);

        // SLT / SLTU sign boundary, back to back with strict latency
        send(32'h8000_0000, 32'h0000_0001, 4'b1000, 4'd1);
        send(32'h8000_0000, 32'h0000_0001, 4'b1001, 4'd2);
        // equal all-ones operands across the remaining ops
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1010, 4'd3);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1011, 4'd4);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1100, 4'd5);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1101, 4'd6);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1110, 4'd8);
        send(32'd5,         32'hFFFF_FFFD, 4'b1111, 4'd9);
        send(32'd5,         32'hFFFF_FFFD, 4'b1110, 4'd10);
        // unsupported op still flows through
        send(32'h1234_5678, 32'h1234_5678, 4'b0011, 4'd7);
        drain();

        // back-pressure: six beats, consumer stalls for cycles 3..7
        strict_lat = 1'b0;
        sent = 0;
        for (int k = 0; k < 40; k++) begin
            out_ready = !(k >= 3 && k <= 7);
            in_valid  = (sent < 6);
            rs_1      = $urandom;
            rs_2      = $urandom;
            alu_ctrl  = 4'($urandom_range(8, 15));
            in_tag    = 4'(sent);
            tick(took);
            if (took) sent++;
            if (sent == 6 && q.size() == 0 && k > 8) break;
        end
        chk("bp_all_sent", sent, 6);
        drain();

        // full throughput with random ops, no bubbles allowed
        strict_lat    = 1'b1;
        track_bubbles = 1'b1;
        last_out      = -1;
        out_ready     = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            in_valid = 1'b1;
            rs_1     = ra;
            rs_2     = rb;
            alu_ctrl = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 7))
                                                   : 4'($urandom_range(8, 15));
            in_tag   = 4'(k);
            tick(took);
            chk("tp_accept", took, 1'b1);
        end
        drain();
        track_bubbles = 1'b0;

        // reset with two beats in flight
        strict_lat = 1'b0;
        out_ready  = 1'b0;
        send(32'd1, 32'd2, 4'b1000, 4'd11);
        send(32'd3, 32'd4, 4'b1001, 4'd12);
        rst_n = 1'b0;
        tick(took);
        rst_n = 1'b1;
        chk("mid_rst_valid",   out_valid,  1'b0);
        chk("mid_rst_result",  result_cmp, 32'd0);
        chk("mid_rst_cond",    cond_true,  1'b0);
        chk("mid_rst_illegal", illegal_op, 1'b0);
        chk("mid_rst_tag",     out_tag,    4'd0);
        chk("mid_rst_ready",   in_ready,   1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick(took);

        // single-stage 8-bit instance, SLT then SLTU at the sign boundary
        d1_in_valid = 1'b1;  d1_rs_1 = 8'h80;  d1_rs_2 = 8'h01;
        d1_alu_ctrl = 4'b1000;  d1_in_tag = 4'd3;
        chk("d1_in_ready", d1_in_ready, 1'b1);
        tick(took);
        d1_alu_ctrl = 4'b1001;  d1_in_tag = 4'd4;
        chk("d1_slt_valid",  d1_out_valid,  1'b1);
        chk("d1_slt_result", d1_result_cmp, 8'h01);
        chk("d1_slt_cond",   d1_cond_true,  1'b1);
        chk("d1_slt_tag",    d1_out_tag,    4'd3);
        tick(took);
        d1_in_valid = 1'b0;
        chk("d1_sltu_valid",  d1_out_valid,  1'b1);
        chk("d1_sltu_result", d1_result_cmp, 8'h00);
        chk("d1_sltu_tag",    d1_out_tag,    4'd4);
        tick(took);
        chk("d1_idle_valid", d1_out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
